// File: rtl/fwd_hazard_unit.sv
// Forwarding/load-use hazard unit: tag shift pipeline EX..slot NSTG, combinational fwd selects and ID stall (0 added latency).
// Backpressure: pipe_hold freezes all slots and raises stall. Optional perf counters via `define FWD_PERF_CNT_EN.
module fwd_hazard_unit #(
   parameter int ADDR_W   = 5,
   parameter int NSTG     = 2,
   parameter int LOAD_STG = 2,
   parameter int SEL_W    = $clog2(NSTG + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [ADDR_W-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_flush,
   input  logic              pipe_hold,
   output logic              stall,
   output logic [SEL_W-1:0]  fwd_a,
   output logic [SEL_W-1:0]  fwd_b
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_fwd_cnt
`endif
);

   logic [ADDR_W-1:0] s0_rs;
   logic [ADDR_W-1:0] s0_rt;
   logic              s0_uses_rs;
   logic              s0_uses_rt;
   logic [ADDR_W-1:0] dst [0:NSTG];
   logic [NSTG:0]     rw;
   logic [NSTG:0]     mr;

   logic load_hit;
   logic haz_stall;
   logic accept;

   // Loads sitting in slots younger than LOAD_STG-1 cannot supply data yet.
   always_comb begin
      load_hit = 1'b0;
      for (int p = 0; p < LOAD_STG - 1; p++) begin
         if (rw[p] && mr[p] && (dst[p] != '0) &&
             ((id_uses_rs && (id_rs == dst[p])) || (id_uses_rt && (id_rt == dst[p]))))
            load_hit = 1'b1;
      end
   end

   assign haz_stall = id_valid & load_hit & ~ex_flush;
   assign stall     = haz_stall | pipe_hold;
   assign accept    = id_valid & ~haz_stall & ~ex_flush;

   // Scan oldest to youngest so the youngest matching producer overwrites.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = NSTG; k >= 1; k--) begin
         if (rw[k] && (dst[k] != '0) && s0_uses_rs && (dst[k] == s0_rs))
            fwd_a = SEL_W'(k);
         if (rw[k] && (dst[k] != '0) && s0_uses_rt && (dst[k] == s0_rt))
            fwd_b = SEL_W'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_rs      <= '0;
         s0_rt      <= '0;
         s0_uses_rs <= 1'b0;
         s0_uses_rt <= 1'b0;
         rw         <= '0;
         mr         <= '0;
         for (int k = 0; k <= NSTG; k++)
            dst[k] <= '0;
      end else if (!pipe_hold) begin
         for (int k = NSTG; k >= 1; k--)
            dst[k] <= dst[k-1];
         rw[NSTG:1] <= rw[NSTG-1:0];
         mr[NSTG:1] <= mr[NSTG-1:0];
         if (accept) begin
            s0_rs      <= id_rs;
            s0_rt      <= id_rt;
            s0_uses_rs <= id_uses_rs;
            s0_uses_rt <= id_uses_rt;
            dst[0]     <= id_dst;
            rw[0]      <= id_reg_write;
            mr[0]      <= id_mem_read;
         end else begin
            s0_rs      <= '0;
            s0_rt      <= '0;
            s0_uses_rs <= 1'b0;
            s0_uses_rt <= 1'b0;
            dst[0]     <= '0;
            rw[0]      <= 1'b0;
            mr[0]      <= 1'b0;
         end
      end
   end

`ifdef FWD_PERF_CNT_EN
   // Held cycles are excluded from the stall count; both counters saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         if (haz_stall && !pipe_hold && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (((fwd_a != '0) || (fwd_b != '0)) && (perf_fwd_cnt != 32'hFFFF_FFFF))
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: two instances (NSTG=2/LOAD_STG=2 and NSTG=3/LOAD_STG=3) share one input stream.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       ex_flush, pipe_hold;
   logic       stall_a, stall_b;
   logic [1:0] fa_a, fb_a, fa_b, fb_b;

   typedef struct {
      string      tag;
      logic       sa;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       sb;
      logic [1:0] ga;
      logic [1:0] gb;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit u_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
      .pipe_hold(pipe_hold), .stall(stall_a), .fwd_a(fa_a), .fwd_b(fb_a)
   );

   fwd_hazard_unit #(.NSTG(3), .LOAD_STG(3)) u_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
      .pipe_hold(pipe_hold), .stall(stall_b), .fwd_a(fa_b), .fwd_b(fb_b)
   );

   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic fl, input logic hd);
      @(negedge clk);
      id_valid = v;   id_rs = rs;   id_rt = rt;
      id_uses_rs = urs; id_uses_rt = urt; id_dst = dst;
      id_reg_write = rw; id_mem_read = mr;
      ex_flush = fl;  pipe_hold = hd;
   endtask

   task automatic idle(input logic fl, input logic hd);
      drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, fl, hd);
   endtask

   task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, obs, want);
      end
   endtask

   task automatic chk_out(input string tag, input logic sa, input logic [1:0] fa,
                          input logic [1:0] fb, input logic sb, input logic [1:0] ga,
                          input logic [1:0] gb);
      exp_t e;
      e.tag = tag; e.sa = sa; e.fa = fa; e.fb = fb; e.sb = sb; e.ga = ga; e.gb = gb;
      q.push_back(e);
      #1;
      e = q.pop_front();
      cmp({e.tag, ".a.stall"}, {1'b0, stall_a}, {1'b0, e.sa});
      cmp({e.tag, ".a.fwd_a"}, fa_a, e.fa);
      cmp({e.tag, ".a.fwd_b"}, fb_a, e.fb);
      cmp({e.tag, ".b.stall"}, {1'b0, stall_b}, {1'b0, e.sb});
      cmp({e.tag, ".b.fwd_a"}, fa_b, e.ga);
      cmp({e.tag, ".b.fwd_b"}, fb_b, e.gb);
   endtask

   task automatic do_reset(input string tag);
      idle(1'b0, 1'b0);
      rst_n = 1'b0;
      chk_out(tag, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_dst = 0; id_reg_write = 0; id_mem_read = 0; ex_flush = 0; pipe_hold = 0;
      chk_out("reset", 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;

      // ALU producer then consumer: forward from slot 1
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); chk_out("alu_c1", 0, 0, 0, 0, 0, 0);
      drv(1, 3, 0, 1, 0, 8, 1, 0, 0, 0); chk_out("alu_c2", 0, 0, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("alu_fwd", 0, 1, 0, 0, 1, 0);

      // Two producers of r5: youngest wins, then only the older writes
      do_reset("rst2");
      drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk_out("yng_c1", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk_out("yng_c2", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 5, 0, 1, 9, 1, 0, 0, 0); chk_out("yng_c3", 0, 0, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("yng_fwd", 0, 0, 1, 0, 0, 1);
      do_reset("rst3");
      drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk_out("old_c1", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0); chk_out("old_c2", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 5, 0, 1, 9, 1, 0, 0, 0); chk_out("old_c3", 0, 0, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("old_fwd", 0, 0, 2, 0, 0, 2);

      // Load-use: 1 stall cycle for LOAD_STG=2, 2 for LOAD_STG=3
      do_reset("rst4");
      drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); chk_out("lu_ld", 0, 0, 0, 0, 0, 0);
      drv(1, 7, 0, 1, 0, 9, 1, 0, 0, 0); chk_out("lu_st1", 1, 0, 0, 1, 0, 0);
      drv(1, 7, 0, 1, 0, 9, 1, 0, 0, 0); chk_out("lu_st2", 0, 0, 0, 1, 0, 0);
      drv(1, 7, 0, 1, 0, 9, 1, 0, 0, 0); chk_out("lu_fwd_a", 0, 2, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("lu_fwd_b", 0, 0, 0, 0, 3, 0);

      // Register 0 never forwards or stalls
      do_reset("rst5");
      drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk_out("r0_c1", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 1, 0, 9, 1, 0, 0, 0); chk_out("r0_c2", 0, 0, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("r0_fwd", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); chk_out("r0_ld", 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 1, 1, 9, 1, 0, 0, 0); chk_out("r0_nostall", 0, 0, 0, 0, 0, 0);

      // Flush beats the load-use stall and leaves a bubble
      do_reset("rst6");
      drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); chk_out("fl_ld", 0, 0, 0, 0, 0, 0);
      drv(1, 7, 0, 1, 0, 9, 1, 0, 1, 0); chk_out("fl_nostall", 0, 0, 0, 0, 0, 0);
      idle(0, 0);                        chk_out("fl_bubble", 0, 0, 0, 0, 0, 0);

      // Hold freezes slots (flush ignored under hold), then shifting resumes
      do_reset("rst7");
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); chk_out("hd_c1", 0, 0, 0, 0, 0, 0);
      drv(1, 3, 0, 1, 0, 4, 1, 0, 0, 0); chk_out("hd_c2", 0, 0, 0, 0, 0, 0);
      idle(0, 1);                        chk_out("hold1", 1, 1, 0, 1, 1, 0);
      idle(1, 1);                        chk_out("hold2_fl", 1, 1, 0, 1, 1, 0);
      idle(0, 1);                        chk_out("hold3", 1, 1, 0, 1, 1, 0);
      drv(1, 0, 4, 0, 1, 10, 1, 0, 0, 0); chk_out("hold_rel", 0, 1, 0, 0, 1, 0);
      idle(0, 0);                        chk_out("shift", 0, 0, 1, 0, 0, 1);

      // Asynchronous reset clears forwarding without a clock edge
      rst_n = 1'b0;
      chk_out("async_rst", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
